mfp_board_io_ctrl: RTL and testbench
====================================

MFP_BOARD_IO_CTRL -- requirements
Module: mfp_board_io_ctrl

Interface
REQ-001 Parameter N_SW, 18, number of slide-switch channels (1..32).
REQ-002 Parameter N_PB, 4, number of pushbutton channels (1..8).
REQ-003 Parameter N_LED, 18, number of LED channels (1..32).
REQ-004 Parameter SYNC_STAGES, 2, synchroniser depth per input (2..4).
REQ-005 Parameter DB_CYCLES, 500000, debounce qualification length in clocks (>=2).
REQ-006 Parameter BLINK_DIV, 12500000, clocks per blink half-period (>=2).
REQ-007 SI_ClkIn  in  1  sole clock; every flop is rising-edge on it.
REQ-008 SI_Reset_N  in  1  reset, synchronous and active-low.
REQ-009 SW_raw  in  N_SW  raw asynchronous switch levels, 1 = up.
REQ-010 PB_raw_n  in  N_PB  raw asynchronous pushbutton levels, 0 = pressed.
REQ-011 SW_db  out  N_SW  debounced switch levels.
REQ-012 PB_db  out  N_PB  debounced pushbutton levels, 1 = pressed.
REQ-013 PB_press  out  N_PB  one-cycle pulse per channel on debounced press.
REQ-014 PB_release  out  N_PB  one-cycle pulse per channel on debounced release.
REQ-015 SW_change  out  1  one-cycle pulse when any SW_db bit changes.
REQ-016 LED_value  in  N_LED  requested LED levels from bus/GPIO logic.
REQ-017 LED_blink_en  in  N_LED  per-LED blink enable.
REQ-018 LED_out  out  N_LED  registered LED drive, 1 = lit.

Function
REQ-019 Each input bit SHALL pass through its own SYNC_STAGES-flop chain; PB bits SHALL be inverted at chain output (pressed = 1).
REQ-020 Each channel SHALL own a counter of width clog2(DB_CYCLES) plus a stable bit; stable bit drives SW_db/PB_db.
REQ-021 Synced value == stable: counter SHALL clear to 0.
REQ-022 Synced value != stable and counter < DB_CYCLES-1: counter SHALL increment by 1.
REQ-023 Synced value != stable and counter == DB_CYCLES-1: stable SHALL take the synced value and counter SHALL clear.
REQ-024 Latency: a raw level held constant SHALL appear on SW_db/PB_db exactly SYNC_STAGES+DB_CYCLES clocks after the first edge sampling it.
REQ-025 Glitch: any raw pulse shorter than DB_CYCLES clocks (after sync) SHALL NOT change the debounced output; counter restarts from 0 on each bounce.
REQ-026 PB_press[i] SHALL be 1 exactly in the first cycle PB_db[i] reads 1; PB_release[i] exactly in the first cycle PB_db[i] reads 0; never both.
REQ-027 SW_change SHALL be 1 exactly in the first cycle any SW_db bit differs from its prior-cycle value; simultaneous changes on several bits SHALL give a single pulse.
REQ-028 Channels SHALL be fully independent; simultaneous qualification on several channels SHALL update all in the same cycle.
REQ-029 Blink divider SHALL count 0..BLINK_DIV-1 and wrap; on wrap the blink phase bit SHALL toggle.
REQ-030 LED_out[i] SHALL register LED_value[i] & (LED_blink_en[i] ? phase : 1), one clock after the inputs.
REQ-031 Change of LED_blink_en SHALL NOT reset the divider or phase; all blinking LEDs remain in phase.

Reset
REQ-032 With SI_Reset_N low at a rising edge, all sync flops SHALL load the idle level (SW 0, PB_raw_n 1), all counters 0, stable bits 0, phase 0, divider 0.
REQ-033 During and in the first cycle after reset, SW_db, PB_db, PB_press, PB_release, SW_change and LED_out SHALL all be 0.
REQ-034 Reset asserted mid-qualification SHALL discard partial counts; no pulse SHALL be emitted for the aborted transition.
REQ-035 A switch held up through reset SHALL appear after SYNC_STAGES+DB_CYCLES clocks with one SW_change pulse.

Verification (SYNC_STAGES=2, DB_CYCLES=4, BLINK_DIV=8)
REQ-036 PB_raw_n[0] 1->0 held -> PB_db[0]=1 and PB_press[0]=1 exactly 6 clocks later, PB_press low the next cycle.
REQ-037 SW_raw[3] bounces 0/1 every 2 clocks for 20 clocks then holds 1 -> SW_db[3] stays 0 during bounce, rises 6 clocks after final edge, one SW_change pulse.
REQ-038 SW_raw[0] and SW_raw[17] rise on the same edge -> both SW_db bits rise on the same cycle, SW_change one cycle wide.
REQ-039 LED_value=all ones, LED_blink_en=0x00001 -> LED_out[0] toggles every 8 clocks, LED_out[17:1] steady 1 after one-clock latency.
REQ-040 PB_raw_n[1] low for 4 clocks, SI_Reset_N low 1 clock, PB held -> no pulse before reset; PB_press[1] 6 clocks after reset release.

Source files
------------

// File: rtl/mfp_board_io_ctrl.sv
// Purpose : board I/O front end: synchronise and debounce slide switches and pushbuttons,
//           emit press/release/change pulses, and drive LEDs with an optional common blink.
// Latency : raw input to debounced level SYNC_STAGES+DB_CYCLES clocks; pulses coincide with the
//           debounced edge; LED_out one clock after LED_value/LED_blink_en.
// Backpr. : none; free-running level interface, every output is registered.
// Ports   : SI_ClkIn/SI_Reset_N clock and sync active-low reset; SW_raw/PB_raw_n raw inputs;
//           SW_db/PB_db debounced levels; PB_press/PB_release/SW_change event pulses;
//           LED_value/LED_blink_en LED requests; LED_out registered LED drive.
module mfp_board_io_ctrl #(
  parameter int N_SW        = 18,
  parameter int N_PB        = 4,
  parameter int N_LED       = 18,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 500000,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic             SI_ClkIn,
  input  logic             SI_Reset_N,
  input  logic [N_SW-1:0]  SW_raw,
  input  logic [N_PB-1:0]  PB_raw_n,
  output logic [N_SW-1:0]  SW_db,
  output logic [N_PB-1:0]  PB_db,
  output logic [N_PB-1:0]  PB_press,
  output logic [N_PB-1:0]  PB_release,
  output logic             SW_change,
  input  logic [N_LED-1:0] LED_value,
  input  logic [N_LED-1:0] LED_blink_en,
  output logic [N_LED-1:0] LED_out
);

  // Switches and buttons share one debounce array: channels [N_SW-1:0] are switches,
  // [N_CH-1:N_SW] are buttons (already inverted to pressed = 1).
  localparam int N_CH = N_SW + N_PB;
  localparam int CW   = $clog2(DB_CYCLES);
  localparam int BW   = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SYNC_STAGES-1:0][N_SW-1:0] sw_sync_q, sw_sync_d;
  logic [SYNC_STAGES-1:0][N_PB-1:0] pb_sync_q, pb_sync_d;
  logic [N_CH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [N_CH-1:0]                  stable_q, stable_d;
  logic [N_CH-1:0]                  synced;
  logic [N_CH-1:0]                  qualify;
  logic [N_PB-1:0]                  pb_press_q, pb_press_d;
  logic [N_PB-1:0]                  pb_release_q, pb_release_d;
  logic                             sw_change_q, sw_change_d;
  logic [BW-1:0]                    div_q, div_d;
  logic                             phase_q, phase_d;
  logic [N_LED-1:0]                 led_q, led_d;

  // Synchronisers: stage 0 captures the raw pin, the last stage feeds the debouncers.
  always_comb begin
    sw_sync_d = {sw_sync_q[SYNC_STAGES-2:0], SW_raw};
    pb_sync_d = {pb_sync_q[SYNC_STAGES-2:0], PB_raw_n};
    synced    = {~pb_sync_q[SYNC_STAGES-1], sw_sync_q[SYNC_STAGES-1]};
  end

  // Debounce: the counter measures how long the synced level has disagreed with the
  // stable level; any return to agreement (a bounce) restarts it from zero.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    qualify  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (synced[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          stable_d[i] = synced[i];
          qualify[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Event pulses are registered alongside the stable bits so they line up with the
  // first cycle the new debounced level is visible.
  always_comb begin
    pb_press_d   = qualify[N_CH-1:N_SW] &  synced[N_CH-1:N_SW];
    pb_release_d = qualify[N_CH-1:N_SW] & ~synced[N_CH-1:N_SW];
    sw_change_d  = |qualify[N_SW-1:0];
  end

  // One shared divider/phase keeps every blinking LED in step regardless of when its
  // enable was set.
  always_comb begin
    div_d   = (div_q == BLINK_LAST) ? '0 : div_q + BW'(1);
    phase_d = phase_q ^ (div_q == BLINK_LAST);
    led_d   = LED_value & (~LED_blink_en | {N_LED{phase_q}});
  end

  always_ff @(posedge SI_ClkIn) begin
    if (!SI_Reset_N) begin
      sw_sync_q    <= '0;
      pb_sync_q    <= '1;
      cnt_q        <= '0;
      stable_q     <= '0;
      pb_press_q   <= '0;
      pb_release_q <= '0;
      sw_change_q  <= 1'b0;
      div_q        <= '0;
      phase_q      <= 1'b0;
      led_q        <= '0;
    end else begin
      sw_sync_q    <= sw_sync_d;
      pb_sync_q    <= pb_sync_d;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      pb_press_q   <= pb_press_d;
      pb_release_q <= pb_release_d;
      sw_change_q  <= sw_change_d;
      div_q        <= div_d;
      phase_q      <= phase_d;
      led_q        <= led_d;
    end
  end

  assign SW_db      = stable_q[N_SW-1:0];
  assign PB_db      = stable_q[N_CH-1:N_SW];
  assign PB_press   = pb_press_q;
  assign PB_release = pb_release_q;
  assign SW_change  = sw_change_q;
  assign LED_out    = led_q;

endmodule

// File: tb/tb_mfp_board_io_ctrl.sv
// Bench for mfp_board_io_ctrl with SYNC_STAGES=2, DB_CYCLES=4, BLINK_DIV=8.
// Expectations are queued with the cycle at which they are due and compared by a checker
// that runs 2 time units after every rising edge.
module tb_mfp_board_io_ctrl;

  localparam int NSW  = 18;
  localparam int NPB  = 4;
  localparam int NLED = 18;

  localparam int K_SW    = 0;
  localparam int K_PB    = 1;
  localparam int K_PRESS = 2;
  localparam int K_REL   = 3;
  localparam int K_CHG   = 4;
  localparam int K_LED   = 5;

  logic            clk;
  logic            rst_n;
  logic [NSW-1:0]  sw_raw;
  logic [NPB-1:0]  pb_raw_n;
  logic [NSW-1:0]  sw_db;
  logic [NPB-1:0]  pb_db;
  logic [NPB-1:0]  pb_press;
  logic [NPB-1:0]  pb_release;
  logic            sw_change;
  logic [NLED-1:0] led_value;
  logic [NLED-1:0] led_blink_en;
  logic [NLED-1:0] led_out;

  mfp_board_io_ctrl #(
    .N_SW(NSW), .N_PB(NPB), .N_LED(NLED),
    .SYNC_STAGES(2), .DB_CYCLES(4), .BLINK_DIV(8)
  ) dut (
    .SI_ClkIn     (clk),
    .SI_Reset_N   (rst_n),
    .SW_raw       (sw_raw),
    .PB_raw_n     (pb_raw_n),
    .SW_db        (sw_db),
    .PB_db        (pb_db),
    .PB_press     (pb_press),
    .PB_release   (pb_release),
    .SW_change    (sw_change),
    .LED_value    (led_value),
    .LED_blink_en (led_blink_en),
    .LED_out      (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    logic [17:0] sw;
    logic [3:0]  pbn;
    logic [17:0] exp_sw;
    logic [3:0]  exp_pb;
    logic        exp_chg;
    logic [3:0]  exp_press;
    logic [3:0]  exp_rel;
  } vec_t;

  sb_t  sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   k0       = 0;

  function automatic string kname(input int kind);
    case (kind)
      K_SW:    return "SW_db";
      K_PB:    return "PB_db";
      K_PRESS: return "PB_press";
      K_REL:   return "PB_release";
      K_CHG:   return "SW_change";
      default: return "LED_out";
    endcase
  endfunction

  function automatic logic [31:0] get_out(input int kind);
    logic [31:0] r;
    r = '0;
    case (kind)
      K_SW:    r[NSW-1:0]  = sw_db;
      K_PB:    r[NPB-1:0]  = pb_db;
      K_PRESS: r[NPB-1:0]  = pb_press;
      K_REL:   r[NPB-1:0]  = pb_release;
      K_CHG:   r[0]        = sw_change;
      default: r[NLED-1:0] = led_out;
    endcase
    return r;
  endfunction

  // LED model: phase flips every 8 edges counted from the last reset edge k0; the LED
  // register sees the phase as it stood one edge earlier.
  function automatic logic [31:0] led_model(input int c, input logic [17:0] en);
    logic        ph;
    logic [17:0] r;
    ph = (((c - 1 - k0) / 8) % 2) != 0;
    r  = 18'h3FFFF & ~(en & {18{~ph}});
    return 32'(r);
  endfunction

  task automatic push(input int d, input int kind, input logic [31:0] exp);
    sb_t e;
    int  idx;
    e.due  = cyc + d;
    e.kind = kind;
    e.exp  = exp;
    idx = sb.size();
    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].due > e.due) idx = i;
    sb.insert(idx, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Checker
  initial begin
    sb_t         e;
    logic [31:0] act;
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e   = sb.pop_front();
        act = get_out(e.kind);
        n_checks++;
        if (e.due != cyc || act !== e.exp)
          $display("FAIL %s cyc=%0d due=%0d actual=0x%0h required=0x%0h",
                   kname(e.kind), cyc, e.due, act, e.exp);
        else
          n_pass++;
      end
    end
  end

  vec_t vecs [6];

  initial begin
    logic [17:0] prev_sw;
    logic [3:0]  prev_pb;
    logic [17:0] en;

    vecs[0] = '{18'h00020, 4'hE, 18'h00020, 4'h1, 1'b0, 4'h1, 4'h0};
    vecs[1] = '{18'h20021, 4'hE, 18'h20021, 4'h1, 1'b1, 4'h0, 4'h0};
    vecs[2] = '{18'h20021, 4'hF, 18'h20021, 4'h0, 1'b0, 4'h0, 4'h1};
    vecs[3] = '{18'h00000, 4'h0, 18'h00000, 4'hF, 1'b1, 4'hF, 4'h0};
    vecs[4] = '{18'h3FFFF, 4'h5, 18'h3FFFF, 4'hA, 1'b1, 4'h0, 4'h5};
    vecs[5] = '{18'h00000, 4'hF, 18'h00000, 4'h0, 1'b1, 4'h0, 4'hA};

    // Reset with switch 5 held up and all LEDs requested on.
    rst_n        = 1'b0;
    sw_raw       = 18'h00020;
    pb_raw_n     = 4'hF;
    led_value    = 18'h3FFFF;
    led_blink_en = '0;
    for (int d = 1; d <= 3; d++)
      for (int k = K_SW; k <= K_LED; k++) push(d, k, 32'h0);
    step(3);
    rst_n = 1'b1;
    k0    = cyc;
    push(1, K_LED, 32'h3FFFF);
    for (int d = 1; d <= 5; d++) begin
      push(d, K_SW, 32'h0);
      push(d, K_CHG, 32'h0);
      push(d, K_PB, 32'h0);
    end
    push(6, K_SW, 32'h20);
    push(6, K_CHG, 32'h1);
    push(7, K_CHG, 32'h0);
    step(9);

    // Table of level changes; each settles fully before the next.
    prev_sw = 18'h00020;
    prev_pb = 4'h0;
    for (int v = 0; v < 6; v++) begin
      sw_raw   = vecs[v].sw;
      pb_raw_n = vecs[v].pbn;
      push(5, K_SW,    32'(prev_sw));
      push(5, K_PB,    32'(prev_pb));
      push(5, K_PRESS, 32'h0);
      push(5, K_REL,   32'h0);
      push(5, K_CHG,   32'h0);
      push(6, K_SW,    32'(vecs[v].exp_sw));
      push(6, K_PB,    32'(vecs[v].exp_pb));
      push(6, K_PRESS, 32'(vecs[v].exp_press));
      push(6, K_REL,   32'(vecs[v].exp_rel));
      push(6, K_CHG,   32'(vecs[v].exp_chg));
      push(7, K_PRESS, 32'h0);
      push(7, K_REL,   32'h0);
      push(7, K_CHG,   32'h0);
      prev_sw = vecs[v].exp_sw;
      prev_pb = vecs[v].exp_pb;
      step(9);
    end

    // Switch 3 bounces every 2 clocks for 20 clocks, then holds high.
    for (int t = 0; t < 10; t++) begin
      sw_raw[3] = (t % 2 == 0);
      for (int s = 0; s < 2; s++) begin
        push(1, K_SW, 32'h0);
        push(1, K_CHG, 32'h0);
        step(1);
      end
    end
    sw_raw[3] = 1'b1;
    for (int d = 1; d <= 5; d++) begin
      push(d, K_SW, 32'h0);
      push(d, K_CHG, 32'h0);
    end
    push(6, K_SW, 32'h8);
    push(6, K_CHG, 32'h1);
    push(7, K_SW, 32'h8);
    push(7, K_CHG, 32'h0);
    step(10);

    // Blink: LED0 first, LED1 joins mid-run without disturbing the phase.
    en = '0;
    for (int j = 0; j < 32; j++) begin
      if (j == 0)  en = 18'h00001;
      if (j == 16) en = 18'h00003;
      led_blink_en = en;
      push(1, K_LED, led_model(cyc + 1, en));
      step(1);
    end
    led_blink_en = '0;

    // Button 1 pressed, reset mid-qualification, button still held.
    sw_raw   = '0;
    pb_raw_n = 4'hF;
    step(10);
    pb_raw_n[1] = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      push(d, K_PRESS, 32'h0);
      push(d, K_PB, 32'h0);
    end
    step(4);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    for (int d = 1; d <= 5; d++) begin
      push(d, K_PRESS, 32'h0);
      push(d, K_PB, 32'h0);
    end
    push(6, K_PB, 32'h2);
    push(6, K_PRESS, 32'h2);
    push(7, K_PB, 32'h2);
    push(7, K_PRESS, 32'h0);

    for (int i = 0; i < 40 && sb.size() != 0; i++) step(1);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
      n_checks += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
